gray_decoder: RTL and testbench

- Receiving end of the Gray-code counter interface: samples a Gray-coded bus, converts each sample to binary, and checks that successive codes step by exactly one position in the reflected-Gray sequence.
- Reports wrap-arounds (7->0 for WIDTH=3), counts them, and flags sequence violations.
- Sits downstream of any Gray counter/pointer source (e.g. a crossing pointer) as converter plus integrity monitor.

---
 rtl/gray_decoder_pkg.sv | 24 ++
 rtl/gray_to_bin.sv | 23 ++
 rtl/gray_decoder.sv | 121 ++++++++++++
 tb/tb_gray_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_decoder_pkg.sv
// Shared definitions for the Gray-code decoder and any Gray counter source:
// state encoding, default widths and a generic Gray-to-binary helper.
package gray_decoder_pkg;

  localparam int unsigned GRAY_WIDTH_DEF = 3;
  localparam int unsigned WRAP_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  // Works for any width up to 32 when the code is zero-extended.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational reflected-Gray to binary converter, MSB-first XOR chain.
module gray_to_bin
  import gray_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [WIDTH-1:0] bin_c;

  always_comb begin
    bin_c            = '0;
    bin_c[WIDTH-1]   = gray_i[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      bin_c[i] = bin_c[i+1] ^ gray_i[i];
    end
  end

  assign bin_o = bin_c;

endmodule

// File: rtl/gray_decoder.sv
// Gray-code receiver: converts sampled codes to binary and monitors single-step
// sequencing with wrap counting. Define GRAY_DEC_BACKSTEP_EN to accept backward steps.
module gray_decoder
  import gray_decoder_pkg::*;
#(
  parameter int unsigned WIDTH      = GRAY_WIDTH_DEF,
  parameter int unsigned WRAP_CNT_W = WRAP_CNT_W_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Valid,
  input  logic [WIDTH-1:0]      GrayIn,
  input  logic                  Clear,
  output logic [WIDTH-1:0]      Binary,
  output logic                  BinValid,
  output logic                  Wrap,
  output logic [WRAP_CNT_W-1:0] WrapCount,
  output logic                  Locked,
  output logic                  Error,
  output logic                  Fault
);

  localparam logic [WIDTH-1:0] MAX_CODE = {WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic                    armed_q;
  logic [WIDTH-1:0]        binary_q, binary_d;
  logic                    binvalid_q, binvalid_d;
  logic                    wrap_q, wrap_d;
  logic                    error_q, error_d;
  logic [WRAP_CNT_W-1:0]   wrapcnt_q, wrapcnt_d;
  logic [WIDTH-1:0]        cur_c;
  logic                    step_fwd_c;
  logic                    step_back_c;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray_i (GrayIn),
    .bin_o  (cur_c)
  );

  assign step_fwd_c = (cur_c == binary_q + WIDTH'(1));
`ifdef GRAY_DEC_BACKSTEP_EN
  assign step_back_c = (cur_c == binary_q - WIDTH'(1));
`else
  assign step_back_c = 1'b0;
`endif

  // Next-state and pulse generation; nothing is accepted until one cycle after reset release.
  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    binvalid_d = 1'b0;
    wrap_d     = 1'b0;
    error_d    = 1'b0;
    wrapcnt_d  = wrapcnt_q;
    if (armed_q) begin
      if (Clear) begin
        state_d = ST_UNLOCKED;
      end else if (Valid) begin
        case (state_q)
          ST_UNLOCKED: begin
            binary_d   = cur_c;
            binvalid_d = 1'b1;
            state_d    = ST_LOCKED;
          end
          ST_LOCKED: begin
            if (cur_c == binary_q) begin
              state_d = ST_LOCKED;
            end else if (step_fwd_c) begin
              binary_d   = cur_c;
              binvalid_d = 1'b1;
              if (binary_q == MAX_CODE) begin
                wrap_d = 1'b1;
                if (wrapcnt_q != {WRAP_CNT_W{1'b1}}) begin
                  wrapcnt_d = wrapcnt_q + WRAP_CNT_W'(1);
                end
              end
            end else if (step_back_c) begin
              binary_d   = cur_c;
              binvalid_d = 1'b1;
            end else begin
              error_d = 1'b1;
              state_d = ST_FAULT;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_UNLOCKED;
      armed_q    <= 1'b0;
      binary_q   <= '0;
      binvalid_q <= 1'b0;
      wrap_q     <= 1'b0;
      error_q    <= 1'b0;
      wrapcnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      binary_q   <= binary_d;
      binvalid_q <= binvalid_d;
      wrap_q     <= wrap_d;
      error_q    <= error_d;
      wrapcnt_q  <= wrapcnt_d;
    end
  end

  assign Binary    = binary_q;
  assign BinValid  = binvalid_q;
  assign Wrap      = wrap_q;
  assign WrapCount = wrapcnt_q;
  assign Error     = error_q;
  assign Locked    = (state_q == ST_LOCKED);
  assign Fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed vectors, a behavioural model
// checked every cycle, and hand-computed literal expectations.
module tb_gray_decoder;

  localparam int W  = 3;
  localparam int WC = 8;
  localparam int N  = 1 << W;
  localparam int CMAX = (1 << WC) - 1;
`ifdef GRAY_DEC_BACKSTEP_EN
  localparam bit BACK = 1'b1;
`else
  localparam bit BACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid = 1'b0;
  logic [W-1:0]  gray = '0;
  logic          clear = 1'b0;
  logic [W-1:0]  binary;
  logic          binvalid, wrap, locked, error, fault;
  logic [WC-1:0] wrapcount;

  int errors = 0;
  int checks = 0;

  gray_decoder #(.WIDTH(W), .WRAP_CNT_W(WC)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .Valid     (valid),
    .GrayIn    (gray),
    .Clear     (clear),
    .Binary    (binary),
    .BinValid  (binvalid),
    .Wrap      (wrap),
    .WrapCount (wrapcount),
    .Locked    (locked),
    .Error     (error),
    .Fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0=unlocked, 1=locked, 2=fault; values are plain integers.
  int m_state = 0, m_bin = 0, m_cnt = 0;
  int m_bv = 0, m_wrap = 0, m_err = 0;
  bit m_armed = 1'b0;

  function automatic int g2b(input int g);
    int b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b % N;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_bin = 0; m_cnt = 0;
      m_bv = 0; m_wrap = 0; m_err = 0; m_armed = 1'b0;
    end else begin
      int cur;
      m_bv = 0; m_wrap = 0; m_err = 0;
      cur = g2b(int'(gray));
      if (!m_armed) m_armed = 1'b1;
      else if (clear) m_state = 0;
      else if (valid) begin
        if (m_state == 0) begin
          m_bin = cur; m_bv = 1; m_state = 1;
        end else if (m_state == 1) begin
          if (cur == m_bin) begin
            m_bv = 0;
          end else if (cur == (m_bin + 1) % N) begin
            if (m_bin == N - 1) begin
              m_wrap = 1;
              if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end
            m_bin = cur; m_bv = 1;
          end else if (BACK && cur == (m_bin + N - 1) % N) begin
            m_bin = cur; m_bv = 1;
          end else begin
            m_err = 1; m_state = 2;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("cmp_binary",   int'(binary),    m_bin);
    chk("cmp_binvalid", int'(binvalid),  m_bv);
    chk("cmp_wrap",     int'(wrap),      m_wrap);
    chk("cmp_wrapcnt",  int'(wrapcount), m_cnt);
    chk("cmp_locked",   int'(locked),    int'(m_state == 1));
    chk("cmp_fault",    int'(fault),     int'(m_state == 2));
    chk("cmp_error",    int'(error),     m_err);
  end

  task automatic step(input logic v, input logic [W-1:0] g, input logic c);
    valid = v; gray = g; clear = c;
    @(negedge clk);
  endtask

  logic [W-1:0] gseq [9];

  initial begin
    gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_binary", int'(binary), 0);
    chk("reset_locked", int'(locked), 0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);

    // Full forward sweep with one wrap.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, gseq[i], 1'b0);
      chk("t1_binary", int'(binary), i % 8);
      chk("t1_binvalid", int'(binvalid), 1);
      chk("t1_locked", int'(locked), 1);
    end
    chk("t1_wrap", int'(wrap), 1);
    chk("t1_wrapcount", int'(wrapcount), 1);

    // Holds produce no BinValid.
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b011, 1'b0);
    repeat (2) begin
      step(1'b1, 3'b011, 1'b0);
      chk("t2_hold_bv", int'(binvalid), 0);
      chk("t2_hold_bin", int'(binary), 2);
    end
    step(1'b1, 3'b010, 1'b0);
    chk("t2_bin3", int'(binary), 3);
    chk("t2_bv3", int'(binvalid), 1);

    // Jump -> error, fault, clear, resync.
    step(1'b0, '0, 1'b1);
    chk("t3_unlocked", int'(locked), 0);
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b110, 1'b0);
    chk("t3_error", int'(error), 1);
    chk("t3_fault", int'(fault), 1);
    chk("t3_bin_kept", int'(binary), 1);
    step(1'b1, 3'b111, 1'b0);
    chk("t3_error_once", int'(error), 0);
    chk("t3_ignored", int'(binary), 1);
    step(1'b0, '0, 1'b1);
    chk("t3_cleared", int'(fault), 0);
    step(1'b1, 3'b111, 1'b0);
    chk("t3_bin5", int'(binary), 5);
    chk("t3_relock", int'(locked), 1);

    // 3 -> 1 is never legal; backward steps depend on the build option.
    step(1'b0, '0, 1'b1);
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    chk("t4_skip_err", int'(error), 1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b011, 1'b0);
`ifdef GRAY_DEC_BACKSTEP_EN
    chk("t4_back_bin", int'(binary), 2);
    chk("t4_back_bv", int'(binvalid), 1);
`else
    chk("t4_back_err", int'(error), 1);
    chk("t4_back_bin", int'(binary), 3);
`endif
    step(1'b0, '0, 1'b1);
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b100, 1'b0);
`ifdef GRAY_DEC_BACKSTEP_EN
    chk("t4_0to7_bin", int'(binary), 7);
    chk("t4_0to7_wrap", int'(wrap), 0);
`else
    chk("t4_0to7_err", int'(error), 1);
`endif
    chk("t4_wrapcount", int'(wrapcount), 1);

    // Clear beats a simultaneous sample.
    step(1'b0, '0, 1'b1);
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b001, 1'b1);
    chk("t5_locked", int'(locked), 0);
    chk("t5_bv", int'(binvalid), 0);
    chk("t5_bin", int'(binary), 0);

    // Saturate the wrap counter.
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < N; i++) step(1'b1, W'(i ^ (i >> 1)), 1'b0);
    end
    chk("t6_saturated", int'(wrapcount), 255);
    chk("t6_bin7", int'(binary), 7);

    // Asynchronous reset mid-cycle, then a sample on the release cycle.
    step(1'b1, 3'b000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_bin", int'(binary), 0);
    chk("t7_async_cnt", int'(wrapcount), 0);
    chk("t7_async_bv", int'(binvalid), 0);
    chk("t7_async_wrap", int'(wrap), 0);
    chk("t7_async_locked", int'(locked), 0);
    @(negedge clk);
    valid = 1'b1; gray = 3'b001; clear = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_release_ignored", int'(binvalid), 0);
    chk("t7_release_bin", int'(binary), 0);
    step(1'b1, 3'b001, 1'b0);
    chk("t7_first_bin", int'(binary), 1);
    chk("t7_first_locked", int'(locked), 1);
    step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
